// File: rtl/period_meter_pkg.sv
// Shared types and defaults for the period meter.
// Optional glitch filter is enabled by PERIOD_METER_FILTER_EN.
package period_meter_pkg;

    localparam int DEF_COUNT_WIDTH = 14;
    localparam int DEF_FILTER_LEN  = 3;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MEASURE = 1'b1
    } state_t;

endpackage

// File: rtl/sig_sync_edge.sv
// Synchronizer, optional glitch filter and edge detector.
// Filter is built only when PERIOD_METER_FILTER_EN is defined.
module sig_sync_edge
    import period_meter_pkg::*;
#(
    parameter int FILTER_LEN = DEF_FILTER_LEN
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_in,
    output logic level,
    output logic sig_edge
);

    if (FILTER_LEN < 1) begin : g_bad_len
        $error("FILTER_LEN must be at least 1");
    end

    logic s1;
    logic s2;
    logic s3;

`ifdef PERIOD_METER_FILTER_EN
    localparam int FCW = $clog2(FILTER_LEN + 1);

    logic           filt;
    logic [FCW-1:0] fcnt;

    // two-flop synchronizer; s3 tracks the filtered level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= sig_in;
            s2 <= s1;
            s3 <= filt;
        end
    end

    // accept a new level only after FILTER_LEN stable cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt <= 1'b0;
            fcnt <= '0;
        end else if (s2 == filt) begin
            fcnt <= '0;
        end else if (fcnt == FCW'(FILTER_LEN - 1)) begin
            filt <= s2;
            fcnt <= '0;
        end else begin
            fcnt <= fcnt + FCW'(1);
        end
    end

    assign sig_edge = filt ^ s3;
    assign level    = s3;
`else
    // two-flop synchronizer plus history flop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= sig_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign sig_edge = s2 ^ s3;
    assign level    = s3;
`endif

endmodule

// File: rtl/period_meter.sv
// Half-period meter with valid/ready result and overrun flag.
// Glitch filter in sig_sync_edge via PERIOD_METER_FILTER_EN.
module period_meter
    import period_meter_pkg::*;
#(
    parameter int COUNT_WIDTH = DEF_COUNT_WIDTH,
    parameter int FILTER_LEN  = DEF_FILTER_LEN
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sig_in,
    input  logic                   meas_ready,
    output logic                   meas_valid,
    output logic [COUNT_WIDTH-1:0] half_period,
    output logic                   meas_level,
    output logic                   overflow,
    output logic                   overrun
);

    localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

    logic level;
    logic sig_edge;

    state_t                 state;
    state_t                 state_n;
    logic [COUNT_WIDTH-1:0] count;
    logic [COUNT_WIDTH-1:0] count_n;
    logic                   res_load;
    logic [COUNT_WIDTH-1:0] res_hp;
    logic                   res_lvl;
    logic                   res_ovf;

    sig_sync_edge #(
        .FILTER_LEN(FILTER_LEN)
    ) u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .sig_in  (sig_in),
        .level   (level),
        .sig_edge(sig_edge)
    );

    // next state, counter update and result capture
    always_comb begin
        state_n  = state;
        count_n  = count;
        res_load = 1'b0;
        res_hp   = '0;
        res_lvl  = level;
        res_ovf  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (sig_edge) begin
                    count_n = '0;
                    state_n = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                if (count == CNT_MAX) begin
                    res_load = 1'b1;
                    res_hp   = CNT_MAX;
                    res_ovf  = 1'b1;
                    count_n  = '0;
                    if (!sig_edge) begin
                        state_n = ST_IDLE;
                    end
                end else if (sig_edge) begin
                    res_load = 1'b1;
                    res_hp   = count + COUNT_WIDTH'(1);
                    count_n  = '0;
                end else begin
                    count_n = count + COUNT_WIDTH'(1);
                end
            end
            default: begin
                state_n = ST_IDLE;
                count_n = '0;
            end
        endcase
    end

    // FSM state and measurement counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            count <= '0;
        end else begin
            state <= state_n;
            count <= count_n;
        end
    end

    // result register with hold, handshake and overrun
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meas_valid  <= 1'b0;
            half_period <= '0;
            meas_level  <= 1'b0;
            overflow    <= 1'b0;
            overrun     <= 1'b0;
        end else if (res_load) begin
            if (!meas_valid || meas_ready) begin
                meas_valid  <= 1'b1;
                half_period <= res_hp;
                meas_level  <= res_lvl;
                overflow    <= res_ovf;
            end else begin
                overrun <= 1'b1;
            end
        end else if (meas_valid && meas_ready) begin
            meas_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_period_meter.sv
// Self-checking bench for period_meter.
// Works with or without PERIOD_METER_FILTER_EN.
module tb_period_meter;

    localparam int CW  = 14;
    localparam int FL  = 3;
    localparam int MAX = (1 << CW) - 1;
`ifdef PERIOD_METER_FILTER_EN
    localparam int LAT = 3 + FL;
`else
    localparam int LAT = 3;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          sig_in = 1'b0;
    logic          meas_ready = 1'b0;
    logic          meas_valid;
    logic [CW-1:0] half_period;
    logic          meas_level;
    logic          overflow;
    logic          overrun;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    int          tt[$];
    bit          lv[$];
    logic [15:0] q[$];
    logic [15:0] exp_q[$];

    period_meter #(
        .COUNT_WIDTH(CW),
        .FILTER_LEN (FL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sig_in     (sig_in),
        .meas_ready (meas_ready),
        .meas_valid (meas_valid),
        .half_period(half_period),
        .meas_level (meas_level),
        .overflow   (overflow),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && meas_valid && meas_ready)
            q.push_back({overflow, meas_level, half_period});
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst_n = 1'b0;
        sig_in = 1'b0;
        meas_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tt.delete();
        lv.delete();
        q.delete();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic toggle_after(input int n);
        repeat (n) @(posedge clk);
        #1 sig_in = ~sig_in;
        tt.push_back(cyc);
        lv.push_back(sig_in);
    endtask

    // expected results from toggle times: each gap is one
    // half-period; gaps beyond MAX saturate and the next
    // toggle restarts the measurement
    task automatic model(input int now);
        int start;
        int gap;
        exp_q.delete();
        start = 0;
        for (int i = 0; i < tt.size(); i++) begin
            if (i > 0) begin
                gap = tt[i] - start;
                if (gap <= MAX)
                    exp_q.push_back({1'b0, lv[i-1], CW'(gap)});
                else
                    exp_q.push_back({1'b1, lv[i-1], CW'(MAX)});
            end
            start = tt[i];
        end
        if (tt.size() > 0 && now - start > MAX + LAT + 3)
            exp_q.push_back({1'b1, lv[tt.size()-1], CW'(MAX)});
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({meas_valid, half_period, meas_level, overflow,
             overrun} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b hp=%0d l=%b o=%b r=%b want 0",
                     meas_valid, half_period, meas_level,
                     overflow, overrun);
        end
        do_reset();
        n_checks++;
        if (meas_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle_valid: got %b want 0",
                     meas_valid);
        end
    endtask

    task automatic test_divider();
        logic [15:0] want;
        do_reset();
        toggle_after(5);
        repeat (50) @(posedge clk);
        #1;
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL div_first_edge: got %0d results want 0",
                     q.size());
        end
        toggle_after(10000 - 50);
        toggle_after(10000);
        toggle_after(10000);
        repeat (LAT + 5) @(posedge clk);
        #1;
        n_checks++;
        if (q.size() != 3) begin
            n_fail++;
            $display("FAIL div_count: got %0d results want 3",
                     q.size());
        end
        for (int i = 0; i < 3 && i < q.size(); i++) begin
            want = {1'b0, (i % 2 == 0), CW'(10000)};
            n_checks++;
            if (q[i] !== want) begin
                n_fail++;
                $display("FAIL div_result%0d: got %h want %h",
                         i, q[i], want);
            end
        end
    endtask

    task automatic test_overflow();
        logic [15:0] want;
        do_reset();
        toggle_after(5);
        toggle_after(100);
        repeat (MAX + 40) @(posedge clk);
        #1;
        want = {1'b1, 1'b0, CW'(MAX)};
        n_checks++;
        if (q.size() != 2 || q[q.size()-1] !== want) begin
            n_fail++;
            $display("FAIL ovf_publish: got n=%0d last=%h want n=2 %h",
                     q.size(), q[q.size()-1], want);
        end
        toggle_after(1);
        repeat (20) @(posedge clk);
        #1;
        n_checks++;
        if (q.size() != 2) begin
            n_fail++;
            $display("FAIL ovf_idle_edge: got %0d results want 2",
                     q.size());
        end
        toggle_after(50 - 20);
        repeat (LAT + 5) @(posedge clk);
        #1;
        model(cyc);
        n_checks++;
        if (q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL ovf_count: got %0d want %0d",
                     q.size(), exp_q.size());
        end
        for (int i = 0; i < q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL ovf_result%0d: got %h want %h",
                         i, q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_hold_overrun();
        do_reset();
        meas_ready = 1'b0;
        toggle_after(5);
        toggle_after(500);
        toggle_after(700);
        repeat (LAT + 5) @(posedge clk);
        #1;
        n_checks++;
        if (meas_valid !== 1'b1 || half_period !== CW'(500) ||
            meas_level !== 1'b1 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_result: got v=%b hp=%0d l=%b o=%b want 1 500 1 0",
                     meas_valid, half_period, meas_level, overflow);
        end
        n_checks++;
        if (overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_overrun: got %b want 1", overrun);
        end
        meas_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if (q.size() != 1 || q[0] !== {1'b0, 1'b1, CW'(500)}) begin
            n_fail++;
            $display("FAIL hold_drain: got n=%0d first=%h want n=1 500",
                     q.size(), q[0]);
        end
        n_checks++;
        if (meas_valid !== 1'b0 || overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_after: got v=%b r=%b want 0 1",
                     meas_valid, overrun);
        end
    endtask

    task automatic test_ready_same_cycle();
        do_reset();
        meas_ready = 1'b0;
        toggle_after(5);
        toggle_after(200);
        repeat (LAT + 3) @(posedge clk);
        #1;
        n_checks++;
        if (meas_valid !== 1'b1 || half_period !== CW'(200)) begin
            n_fail++;
            $display("FAIL same_first: got v=%b hp=%0d want 1 200",
                     meas_valid, half_period);
        end
        toggle_after(300 - (LAT + 3));
        repeat (LAT - 1) @(posedge clk);
        #1 meas_ready = 1'b1;
        @(posedge clk);
        #1 meas_ready = 1'b0;
        n_checks++;
        if (meas_valid !== 1'b1 || half_period !== CW'(300) ||
            meas_level !== 1'b0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL same_load: got v=%b hp=%0d l=%b o=%b want 1 300 0 0",
                     meas_valid, half_period, meas_level, overflow);
        end
        n_checks++;
        if (overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL same_overrun: got %b want 0", overrun);
        end
        n_checks++;
        if (q.size() != 1 || q[0] !== {1'b0, 1'b1, CW'(200)}) begin
            n_fail++;
            $display("FAIL same_handshake: got n=%0d first=%h want 1 200",
                     q.size(), q[0]);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        meas_ready = 1'b0;
        toggle_after(5);
        toggle_after(120);
        toggle_after(80);
        toggle_after(30);
        repeat (10) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({meas_valid, half_period, meas_level, overflow,
             overrun} !== '0) begin
            n_fail++;
            $display("FAIL rst_async: got v=%b hp=%0d l=%b o=%b r=%b want 0",
                     meas_valid, half_period, meas_level,
                     overflow, overrun);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tt.delete();
        lv.delete();
        q.delete();
        meas_ready = 1'b1;
        toggle_after(5);
        repeat (20) @(posedge clk);
        #1;
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL rst_first_edge: got %0d results want 0",
                     q.size());
        end
        toggle_after(250 - 20);
        repeat (LAT + 5) @(posedge clk);
        #1;
        n_checks++;
        if (q.size() != 1 || q[0] !== {1'b0, 1'b1, CW'(250)}) begin
            n_fail++;
            $display("FAIL rst_second_edge: got n=%0d first=%h want 1 250",
                     q.size(), q[0]);
        end
    endtask

    task automatic test_glitch();
        bit seen;
        do_reset();
        toggle_after(5);
        toggle_after(400);
        toggle_after(2);
        toggle_after(598);
        repeat (LAT + 5) @(posedge clk);
        #1;
`ifdef PERIOD_METER_FILTER_EN
        n_checks++;
        if (q.size() != 1 || q[0] !== {1'b0, 1'b1, CW'(1000)}) begin
            n_fail++;
            $display("FAIL glitch_filtered: got n=%0d first=%h want 1 1000",
                     q.size(), q[0]);
        end
        seen = 1'b0;
`else
        model(cyc);
        n_checks++;
        if (q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL glitch_count: got %0d want %0d",
                     q.size(), exp_q.size());
        end
        seen = 1'b0;
        for (int i = 0; i < q.size() && i < exp_q.size(); i++) begin
            if (q[i] === {1'b0, 1'b0, CW'(2)}) seen = 1'b1;
            n_checks++;
            if (q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL glitch_result%0d: got %h want %h",
                         i, q[i], exp_q[i]);
            end
        end
        n_checks++;
        if (seen !== 1'b1) begin
            n_fail++;
            $display("FAIL glitch_split: got no 2-clk result want one");
        end
`endif
    endtask

    task automatic test_random();
        do_reset();
        toggle_after(5);
        for (int i = 0; i < 8; i++)
            toggle_after($urandom_range(1500, 8));
        repeat (LAT + 5) @(posedge clk);
        #1;
        model(cyc);
        n_checks++;
        if (q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL rand_count: got %0d want %0d",
                     q.size(), exp_q.size());
        end
        for (int i = 0; i < q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL rand_result%0d: got %h want %h",
                         i, q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_divider();
        test_overflow();
        test_hold_overrun();
        test_ready_same_cycle();
        test_reset_mid();
        test_glitch();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
